// File: rtl/baccarat_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | baccarat_pkg: round-controller states, draw thresholds, score reduction  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
package baccarat_pkg;

   typedef enum logic [2:0] {
      ST_RESET  = 3'b000,
      ST_DEALP1 = 3'b001,
      ST_DEALD1 = 3'b010,
      ST_DEALP2 = 3'b011,
      ST_DEALD2 = 3'b100,
      ST_DEALP3 = 3'b101,
      ST_DEALD3 = 3'b110,
      ST_WINNER = 3'b111
   } state_t;

   localparam logic [3:0] NATURAL_SCORE   = 4'd8;
   localparam logic [3:0] PLAYER_DRAW_MAX = 4'd5;

   // Hand scores arrive as raw 0..15 sums; only the units digit matters.
   function automatic logic [3:0] reduce_score(input logic [3:0] s);
      return (s >= 4'd10) ? (s - 4'd10) : s;
   endfunction

endpackage
`default_nettype wire

// File: rtl/baccarat_round_ctrl_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | baccarat_round_ctrl_if: controller <-> card datapath signals             |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
interface baccarat_round_ctrl_if;

   logic [3:0] pscore;
   logic [3:0] dscore;
   logic [3:0] pcard3;
   logic       load_pcard1;
   logic       load_pcard2;
   logic       load_pcard3;
   logic       load_dcard1;
   logic       load_dcard2;
   logic       load_dcard3;
   logic       clear_hand;

   modport master (
      input  pscore, dscore, pcard3,
      output load_pcard1, load_pcard2, load_pcard3,
      output load_dcard1, load_dcard2, load_dcard3,
      output clear_hand
   );

   modport slave (
      output pscore, dscore, pcard3,
      input  load_pcard1, load_pcard2, load_pcard3,
      input  load_dcard1, load_dcard2, load_dcard3,
      input  clear_hand
   );

endinterface
`default_nettype wire

// File: rtl/bank_draw_rule.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | bank_draw_rule: banker third-card decision after the player has drawn    |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module bank_draw_rule (
   input  logic [3:0] d,
   input  logic [3:0] pcard3,
   output logic       draw
);

   always_comb begin
      draw = 1'b0;
      case (d)
         4'd0, 4'd1, 4'd2: draw = 1'b1;
         4'd3:             draw = (pcard3 != 4'd8);
         4'd4:             draw = (pcard3 >= 4'd2) && (pcard3 <= 4'd7);
         4'd5:             draw = (pcard3 >= 4'd4) && (pcard3 <= 4'd7);
         4'd6:             draw = (pcard3 >= 4'd6) && (pcard3 <= 4'd7);
         default:          draw = 1'b0;
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/baccarat_round_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | baccarat_round_ctrl: deal sequencing, result lights, tallies, auto-loop  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module baccarat_round_ctrl
   import baccarat_pkg::*;
#(
   parameter int TALLY_W     = 8,
   parameter int HOLD_CYCLES = 3
) (
   input  logic                   slow_clock,
   input  logic                   resetb,
   input  logic                   auto_mode,
   input  logic                   tally_clear,
   baccarat_round_ctrl_if.master  dp,
   output logic                   player_win_light,
   output logic                   dealer_win_light,
   output logic                   round_done,
   output logic [TALLY_W-1:0]     player_tally,
   output logic [TALLY_W-1:0]     dealer_tally,
   output logic [TALLY_W-1:0]     tie_tally,
   output logic [2:0]             present_state
);

   localparam int                DWELL_W    = $clog2(HOLD_CYCLES + 1);
   localparam logic [DWELL_W-1:0] DWELL_MAX  = DWELL_W'(HOLD_CYCLES);
   localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(HOLD_CYCLES - 1);

   state_t               state;
   logic [DWELL_W-1:0]   dwell;
   logic [3:0]           p;
   logic [3:0]           d;
   logic                 bank_draw;
   logic                 in_winner;
   logic                 restart;

   assign p         = reduce_score(dp.pscore);
   assign d         = reduce_score(dp.dscore);
   assign in_winner = (state == ST_WINNER);
   // dwell reads 0 on the first WINNER cycle, so the last one is HOLD_CYCLES-1.
   assign restart   = in_winner && auto_mode && (dwell >= DWELL_LAST);

   bank_draw_rule u_bank_draw_rule (
      .d      (d),
      .pcard3 (dp.pcard3),
      .draw   (bank_draw)
   );

   always_ff @(posedge slow_clock or negedge resetb) begin
      if (!resetb) begin
         state <= ST_RESET;
      end else begin
         case (state)
            ST_RESET:  state <= ST_DEALP1;
            ST_DEALP1: state <= ST_DEALD1;
            ST_DEALD1: state <= ST_DEALP2;
            ST_DEALP2: state <= ST_DEALD2;
            ST_DEALD2: begin
               if ((p >= NATURAL_SCORE) || (d >= NATURAL_SCORE))
                  state <= ST_WINNER;
               else if (p <= PLAYER_DRAW_MAX)
                  state <= ST_DEALP3;
               else if (d <= PLAYER_DRAW_MAX)
                  state <= ST_DEALD3;
               else
                  state <= ST_WINNER;
            end
            ST_DEALP3: state <= bank_draw ? ST_DEALD3 : ST_WINNER;
            ST_DEALD3: state <= ST_WINNER;
            ST_WINNER: if (restart) state <= ST_DEALP1;
            default:   state <= ST_RESET;
         endcase
      end
   end

   always_ff @(posedge slow_clock or negedge resetb) begin
      if (!resetb)
         dwell <= '0;
      else if (!in_winner)
         dwell <= '0;
      else if (dwell != DWELL_MAX)
         dwell <= dwell + DWELL_W'(1);
   end

   always_ff @(posedge slow_clock or negedge resetb) begin
      if (!resetb) begin
         player_tally <= '0;
         dealer_tally <= '0;
         tie_tally    <= '0;
      end else if (tally_clear) begin
         player_tally <= '0;
         dealer_tally <= '0;
         tie_tally    <= '0;
      end else if (round_done) begin
         if (p > d) begin
            if (player_tally != {TALLY_W{1'b1}})
               player_tally <= player_tally + TALLY_W'(1);
         end else if (d > p) begin
            if (dealer_tally != {TALLY_W{1'b1}})
               dealer_tally <= dealer_tally + TALLY_W'(1);
         end else begin
            if (tie_tally != {TALLY_W{1'b1}})
               tie_tally <= tie_tally + TALLY_W'(1);
         end
      end
   end

   always_comb begin
      dp.load_pcard1 = 1'b0;
      dp.load_dcard1 = 1'b0;
      dp.load_pcard2 = 1'b0;
      dp.load_dcard2 = 1'b0;
      dp.load_pcard3 = 1'b0;
      dp.load_dcard3 = 1'b0;
      case (state)
         ST_DEALP1: dp.load_pcard1 = 1'b1;
         ST_DEALD1: dp.load_dcard1 = 1'b1;
         ST_DEALP2: dp.load_pcard2 = 1'b1;
         ST_DEALD2: dp.load_dcard2 = 1'b1;
         ST_DEALP3: dp.load_pcard3 = 1'b1;
         ST_DEALD3: dp.load_dcard3 = 1'b1;
         default:   ;
      endcase
   end

   assign player_win_light = in_winner && (p >= d);
   assign dealer_win_light = in_winner && (d >= p);
   assign round_done       = in_winner && (dwell == '0);
   assign dp.clear_hand    = restart;
   assign present_state    = state;

endmodule
`default_nettype wire

// File: tb/tb_baccarat_round_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_baccarat_round_ctrl: directed rounds with hand-computed expectations  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_baccarat_round_ctrl;

   localparam int TALLY_W     = 2;
   localparam int HOLD_CYCLES = 3;

   localparam logic [2:0] S_RESET  = 3'd0;
   localparam logic [2:0] S_DEALP1 = 3'd1;
   localparam logic [2:0] S_DEALD1 = 3'd2;
   localparam logic [2:0] S_DEALP2 = 3'd3;
   localparam logic [2:0] S_DEALD2 = 3'd4;
   localparam logic [2:0] S_DEALP3 = 3'd5;
   localparam logic [2:0] S_DEALD3 = 3'd6;
   localparam logic [2:0] S_WINNER = 3'd7;

   logic               slow_clock;
   logic               resetb;
   logic               auto_mode;
   logic               tally_clear;
   logic               player_win_light;
   logic               dealer_win_light;
   logic               round_done;
   logic [TALLY_W-1:0] player_tally;
   logic [TALLY_W-1:0] dealer_tally;
   logic [TALLY_W-1:0] tie_tally;
   logic [2:0]         present_state;
   logic [5:0]         loads;

   int checks = 0;
   int passed = 0;

   baccarat_round_ctrl_if bif ();

   baccarat_round_ctrl #(
      .TALLY_W     (TALLY_W),
      .HOLD_CYCLES (HOLD_CYCLES)
   ) dut (
      .slow_clock       (slow_clock),
      .resetb           (resetb),
      .auto_mode        (auto_mode),
      .tally_clear      (tally_clear),
      .dp               (bif),
      .player_win_light (player_win_light),
      .dealer_win_light (dealer_win_light),
      .round_done       (round_done),
      .player_tally     (player_tally),
      .dealer_tally     (dealer_tally),
      .tie_tally        (tie_tally),
      .present_state    (present_state)
   );

   // {pcard1, dcard1, pcard2, dcard2, pcard3, dcard3}
   assign loads = {bif.load_pcard1, bif.load_dcard1, bif.load_pcard2,
                   bif.load_dcard2, bif.load_pcard3, bif.load_dcard3};

   initial slow_clock = 1'b0;
   always #5 slow_clock = ~slow_clock;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge slow_clock);
      #1;
   endtask

   task automatic set_hand(input logic [3:0] ps, input logic [3:0] ds, input logic [3:0] pc);
      bif.pscore = ps;
      bif.dscore = ds;
      bif.pcard3 = pc;
   endtask

   // Entered while in DEALP1; leaves the FSM in DEALD2.
   task automatic deal_to_d2();
      chk("st_dealp1", present_state, S_DEALP1);
      chk("ld_dealp1", loads, 6'b100000);
      tick();
      chk("st_deald1", present_state, S_DEALD1);
      chk("ld_deald1", loads, 6'b010000);
      tick();
      chk("st_dealp2", present_state, S_DEALP2);
      chk("ld_dealp2", loads, 6'b001000);
      tick();
      chk("st_deald2", present_state, S_DEALD2);
      chk("ld_deald2", loads, 6'b000100);
   endtask

   // Entered in the first WINNER cycle with auto_mode=1; leaves the FSM in DEALP1.
   task automatic dwell_restart(input int pt, input int dt, input int tt);
      chk("rd_first", round_done, 1'b1);
      chk("ch_first", bif.clear_hand, 1'b0);
      tick();
      chk("rd_second", round_done, 1'b0);
      chk("ch_second", bif.clear_hand, 1'b0);
      chk("ptally", player_tally, pt);
      chk("dtally", dealer_tally, dt);
      chk("ttally", tie_tally, tt);
      tick();
      chk("st_third", present_state, S_WINNER);
      chk("ch_third", bif.clear_hand, 1'b1);
      tick();
      chk("st_restart", present_state, S_DEALP1);
      chk("ch_restart", bif.clear_hand, 1'b0);
      chk("lights_off", {player_win_light, dealer_win_light}, 2'b00);
   endtask

   initial begin
      resetb      = 1'b1;
      auto_mode   = 1'b0;
      tally_clear = 1'b0;
      set_hand(4'd0, 4'd0, 4'd0);
      #2 resetb = 1'b0;
      tick();
      tick();
      chk("rst_state", present_state, S_RESET);
      chk("rst_tallies", {player_tally, dealer_tally, tie_tally}, 0);
      chk("rst_loads", loads, 6'b000000);
      chk("rst_outs", {player_win_light, dealer_win_light, round_done, bif.clear_hand}, 4'b0000);

      // Natural: player 9 vs dealer 8, WINNER five edges after release.
      set_hand(4'd9, 4'd8, 4'd0);
      resetb = 1'b1;
      tick();
      deal_to_d2();
      tick();
      chk("nat_state", present_state, S_WINNER);
      chk("nat_lights", {player_win_light, dealer_win_light}, 2'b10);
      chk("nat_rd", round_done, 1'b1);
      chk("nat_ptally_pre", player_tally, 0);
      tick();
      chk("nat_rd_end", round_done, 1'b0);
      chk("nat_ptally", player_tally, 1);
      chk("nat_others", {dealer_tally, tie_tally}, 0);
      tick();
      tick();
      tick();
      chk("manual_hold", present_state, S_WINNER);
      chk("manual_ch", bif.clear_hand, 1'b0);

      // Turning auto on after the dwell has saturated takes effect in the same cycle.
      auto_mode = 1'b1;
      #1;
      chk("auto_late_ch", bif.clear_hand, 1'b1);
      tick();
      chk("auto_late_st", present_state, S_DEALP1);

      // Tie 7/7: both players stand, three WINNER cycles, then restart.
      set_hand(4'd7, 4'd7, 4'd0);
      deal_to_d2();
      tick();
      chk("tie_state", present_state, S_WINNER);
      chk("tie_lights", {player_win_light, dealer_win_light}, 2'b11);
      dwell_restart(1, 0, 1);

      // 15/14 reduce to 5/4: player draws, banker on 4 with pcard3=3 draws.
      set_hand(4'd15, 4'd14, 4'd3);
      deal_to_d2();
      tick();
      chk("mod_dealp3", present_state, S_DEALP3);
      chk("mod_ld_p3", loads, 6'b000010);
      tick();
      chk("mod_deald3", present_state, S_DEALD3);
      chk("mod_ld_d3", loads, 6'b000001);
      tick();
      chk("mod_winner", present_state, S_WINNER);
      chk("mod_lights", {player_win_light, dealer_win_light}, 2'b10);
      // 4 vs raw 13 (=3): only the reduced compare favours the player.
      set_hand(4'd4, 4'd13, 4'd3);
      #1;
      chk("mod_cmp", {player_win_light, dealer_win_light}, 2'b10);
      dwell_restart(2, 0, 1);

      // Asynchronous reset in the middle of a round.
      set_hand(4'd0, 4'd6, 4'd6);
      deal_to_d2();
      tick();
      chk("mid_dealp3", present_state, S_DEALP3);
      chk("mid_ptally_pre", player_tally, 2);
      resetb = 1'b0;
      #1;
      chk("mid_rst_state", present_state, S_RESET);
      chk("mid_rst_tallies", {player_tally, dealer_tally, tie_tally}, 0);
      chk("mid_rst_loads", loads, 6'b000000);
      tick();
      chk("mid_rst_hold", present_state, S_RESET);
      resetb = 1'b1;
      tick();

      // Banker 6 draws on pcard3=6.
      deal_to_d2();
      tick();
      chk("bk_dealp3", present_state, S_DEALP3);
      tick();
      chk("bk_deald3", present_state, S_DEALD3);
      tick();
      chk("bk_winner", present_state, S_WINNER);
      chk("bk_lights", {player_win_light, dealer_win_light}, 2'b01);
      dwell_restart(0, 1, 0);

      // Banker 6 stands on pcard3=0.
      set_hand(4'd0, 4'd6, 4'd0);
      deal_to_d2();
      tick();
      chk("bs_dealp3", present_state, S_DEALP3);
      tick();
      chk("bs_winner", present_state, S_WINNER);
      chk("bs_lights", {player_win_light, dealer_win_light}, 2'b01);
      dwell_restart(0, 2, 0);

      // Dealer naturals push the 2-bit tally to saturation.
      set_hand(4'd0, 4'd9, 4'd0);
      deal_to_d2();
      tick();
      chk("sat3_winner", present_state, S_WINNER);
      dwell_restart(0, 3, 0);
      deal_to_d2();
      tick();
      chk("sat4_winner", present_state, S_WINNER);
      dwell_restart(0, 3, 0);

      // Clear coinciding with a player-win round_done edge wins over the increment.
      set_hand(4'd9, 4'd0, 4'd0);
      deal_to_d2();
      tick();
      chk("clr_winner", present_state, S_WINNER);
      chk("clr_rd", round_done, 1'b1);
      tally_clear = 1'b1;
      tick();
      tally_clear = 1'b0;
      chk("clr_tallies", {player_tally, dealer_tally, tie_tally}, 0);
      tick();
      chk("clr_ch", bif.clear_hand, 1'b1);
      tick();
      chk("clr_restart", present_state, S_DEALP1);

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/baccarat_round_ctrl.md
BACCARAT_ROUND_CTRL -- requirements
Module: baccarat_round_ctrl

Interface
REQ-001 Parameters (name, default, meaning): TALLY_W, 8, width of each win tally counter; HOLD_CYCLES, 3, WINNER dwell in cycles before auto-restart (>=2).
REQ-002 slow_clock  input  1  sole clock, rising-edge active.
REQ-003 resetb  input  1  reset, asynchronous, active-low.
REQ-004 auto_mode  input  1  1 = restart the next round automatically after the WINNER dwell; 0 = stay in WINNER until reset.
REQ-005 tally_clear  input  1  synchronous clear of all three tallies.
REQ-006 pscore, dscore  input  4 each  current player/dealer hand score from the datapath.
REQ-007 pcard3  input  4  face value of the player's third card.
REQ-008 load_pcard1..3, load_dcard1..3  output  1 each  card-register load enables.
REQ-009 player_win_light, dealer_win_light  output  1 each  result lights.
REQ-010 round_done  output  1  one-cycle pulse on the first WINNER cycle.
REQ-011 clear_hand  output  1  datapath hand-clear request before an auto-restart.
REQ-012 player_tally, dealer_tally, tie_tally  output  TALLY_W each  round-result counters.
REQ-013 present_state  output  3  current state, for the bench and for debug.

Function
REQ-014 States and encoding: RESET=000, DEALP1=001, DEALD1=010, DEALP2=011, DEALD2=100, DEALP3=101, DEALD3=110, WINNER=111.
REQ-015 Unconditional sequence: RESET->DEALP1->DEALD1->DEALP2->DEALD2, one state per edge.
REQ-016 Score reduction: pscore and dscore values 10-15 are reduced modulo 10 before any compare; pcard3 is used as given.
REQ-017 DEALD2 transitions, with p and d the reduced scores:
- p>=8 or d>=8: to WINNER.
- else p<=5: to DEALP3.
- else (p is 6 or 7) and d<=5: to DEALD3.
- else: to WINNER.
REQ-018 DEALP3 goes to DEALD3 when any of the following holds, otherwise to WINNER:
- d<=2;
- d=3 and pcard3!=8;
- d=4 and pcard3 in 2..7;
- d=5 and pcard3 in 4..7;
- d=6 and pcard3 in 6..7.
REQ-019 DEALD3 goes to WINNER.
REQ-020 Load enables are a Moore decode of present_state:
- load_pcard1 in DEALP1, load_dcard1 in DEALD1;
- load_pcard2 in DEALP2, load_dcard2 in DEALD2;
- load_pcard3 in DEALP3, load_dcard3 in DEALD3;
- all zero in every other state.
REQ-021 Lights, valid only in WINNER: p>d gives player_win_light=1; d>p gives dealer_win_light=1; p=d gives both=1; both are 0 outside WINNER.
REQ-022 round_done is 1 only in the first WINNER cycle after entry.
REQ-023 Tally update: at the edge ending the round_done cycle, exactly one tally increments (player, dealer, or tie per REQ-021), saturating at all ones.
REQ-024 tally_clear=1 zeroes all tallies at the next edge; it takes priority over a simultaneous increment.
REQ-025 WINNER dwell counter: counts cycles in WINNER, saturates at HOLD_CYCLES, and resets whenever the state is not WINNER.
REQ-026 auto_mode=1: the FSM stays in WINNER for exactly HOLD_CYCLES cycles, then goes to DEALP1; clear_hand=1 during the final WINNER cycle only.
REQ-027 auto_mode=0: the FSM remains in WINNER indefinitely and clear_hand stays 0.
REQ-028 auto_mode is sampled each WINNER cycle; a change during the dwell takes effect in that cycle.
REQ-029 A round started by auto-restart runs the same sequence as REQ-015 onwards, excluding RESET.

Reset
REQ-030 resetb=0 immediately forces present_state=RESET, all tallies=0, and the dwell counter=0, at any time including mid-round.
REQ-031 During and after reset, all load enables, lights, round_done and clear_hand are 0 until the state changes.
REQ-032 The first edge with resetb=1 moves the FSM RESET->DEALP1.

Structure
REQ-033 Shared package baccarat_pkg holds the state typedef and encodings, the natural threshold (8) and the player draw limit (5).
REQ-034 Sub-module bank_draw_rule is combinational (inputs d, pcard3; output draw) and implements REQ-018.
REQ-035 The FSM, dwell counter and tallies are in one always_ff block per concern; outputs are decoded combinationally from registered state.

Verification
REQ-036 Natural: after reset, p=9, d=8 -> WINNER after 5 edges, player light only, round_done pulse, player_tally=1 one edge later.
REQ-037 Banker rule: p=0, d=6, pcard3=6 -> DEALP3 -> DEALD3 -> WINNER; repeat with pcard3=0 -> DEALP3 -> WINNER directly.
REQ-038 Auto restart: auto_mode=1, HOLD_CYCLES=3, p=d=7 -> three WINNER cycles, both lights, clear_hand in the 3rd, then DEALP1; tie_tally=1.
REQ-039 Saturation and clear: TALLY_W=2, four dealer wins -> dealer_tally=3; then tally_clear coinciding with a round_done edge -> all tallies 0.
REQ-040 Mid-round reset: resetb low in DEALP3 -> present_state=RESET and tallies=0 immediately without a clock; REQ-036 then passes.
REQ-041 Modulo reduction: p=15, d=14 (reduce to 5 and 4) -> DEALP3 path taken; the final compare uses reduced scores.
